tgt_pyld_fetch: RTL and testbench
=================================

# tgt_pyld_fetch

Fetch sequencer for the P2P target payload buffer. It sits beside the payload buffer block on both of its control sides:
- It sinks the buffer-allocation stream (one entry per filled 4-beat block or per message tail).
- It pairs those entries with message descriptors from the target control path.
- It drives the per-beat free/fetch request stream (address, offset, head, last) back into the payload buffer, which returns the data and recycles the block.

## Interface
Parameters:
- BUF_ADDR_W, 10: payload buffer block index width.
- BLEN_W, 13: message byte-length width.
- HEAD_W, 64: descriptor head width, carried to the fetch stream.
- BEAT_BYTES, 32: bytes per data beat; 4 beats per buffer block.
- AFIFO_LOG, 4: log2 depth of the allocation-entry FIFO.
- DFIFO_LOG, 3: log2 depth of the descriptor FIFO.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pbuf_alloc_valid  in  1  allocation entry valid.
- pbuf_alloc_last  in  1  entry holds the final block of a message.
- pbuf_alloc_buf_addr  in  BUF_ADDR_W  block index.
- pbuf_alloc_qnum  in  8  queue number (recorded, checked).
- pbuf_alloc_ready  out  1  = !afifo_full.
- desc_valid  in  1  message descriptor valid.
- desc_blen  in  BLEN_W  message byte length.
- desc_qnum  in  8  queue number.
- desc_head  in  HEAD_W  head forwarded on every beat.
- desc_ready  out  1  = !dfifo_full.
- pbuf_free_valid  out  1  fetch/free beat valid.
- pbuf_free_last  out  1  final beat of message.
- pbuf_free_head  out  HEAD_W  current descriptor head.
- pbuf_free_buf_offset  out  2  beat index inside block.
- pbuf_free_buf_addr  out  BUF_ADDR_W  block index.
- pbuf_free_ready  in  1  downstream accept.
- seq_err  out  1  sticky protocol-error flag; cleared only by rst.

## Operation
- Both FIFOs are show-ahead synchronous FIFOs:
  - Allocation FIFO entry = {last, qnum, buf_addr}.
  - Descriptor FIFO entry = {blen, qnum, head}.
- Beat count: beats = ceil(blen/BEAT_BYTES), computed as (blen + BEAT_BYTES-1) >> log2(BEAT_BYTES), in a BLEN_W+1-bit sum so there is no overflow. blen = 0 is treated as 1 beat. Beat counter is BLEN_W-4 bits wide (max 256 beats at default widths).
- FSM state IDLE:
  - Entered on reset.
  - If the descriptor FIFO is non-empty: pop it; latch head, qnum and beats_left = beats; clear beat_idx; go to FETCH.
- FSM state FETCH:
  - pbuf_free_valid = !afifo_empty.
  - pbuf_free_buf_addr = afifo head addr.
  - pbuf_free_buf_offset = beat_idx[1:0].
  - pbuf_free_last = (beats_left == 1).
  - pbuf_free_head = latched head.
- On each free handshake (valid & ready):
  - beats_left decrements and beat_idx increments.
  - The allocation FIFO pops when offset == 3 or last == 1.
  - If last == 1, return to IDLE.
- Consistency checks at each allocation pop; any failure sets seq_err and does not alter sequencing:
  - Entry last must equal pbuf_free_last.
  - Entry qnum must equal the latched qnum.
- pbuf_alloc_valid while afifo_full: the entry is dropped and seq_err is set. The upstream treats ready as always high, so AFIFO depth must cover the worst case.

## Timing
- Reset values: pbuf_free_valid 0, pbuf_free_last 0, pbuf_free_head 0, offset 0, buf_addr 0, seq_err 0, FSM IDLE, both FIFOs empty.
- Ready outputs are 1 after reset; they are undriven by FSM state.
- Descriptor accepted at cycle N:
  - Visible in the FIFO at N+1.
  - IDLE pops it at N+1.
  - FETCH from N+2; the first pbuf_free_valid can assert at N+2.
- An allocation entry written at cycle M is usable by FETCH from M+1.
- Throughput is one beat per cycle while pbuf_free_ready = 1 and entries are available. Exactly one idle cycle (IDLE) follows each message's last beat.
- Stall: while pbuf_free_valid & !pbuf_free_ready, all pbuf_free_* outputs hold stable.
- Valid drops only when the allocation FIFO runs empty. It never drops mid-handshake: if valid is high and ready is low, no pop occurs.
- Simultaneous allocation push and pop on a full or empty FIFO:
  - Full: the push is refused; pop before push is not allowed.
  - Empty: the write is visible the next cycle; there is no same-cycle bypass.
- rst mid-message: the in-flight message is abandoned, both FIFOs are flushed, and all outputs return to reset values on the next edge.

## Test plan
- Single message: blen=100, one alloc {addr=5, last=1}, ready=1 -> 4 beats, addr 5, offsets 0,1,2,3, last on beat 4, one pop, seq_err=0.
- Multi-block message: blen=200 (7 beats), allocs {addr=9,last=0},{addr=3,last=1} -> offsets 0-3 on addr 9, then 0-2 on addr 3, last on offset 2.
- Backpressure: blen=64, ready toggled 1,0,0,1 -> beat 2 held stable for 3 cycles with identical addr/offset/head; total 2 handshakes.
- Alloc-late: descriptor first, alloc entry arrives 5 cycles later -> valid low until the cycle after the entry is written, then 1 beat per cycle.
- Mismatch: blen=32 but alloc last=0 -> 1 beat with last=1, seq_err=1 and stays 1 until rst.
- Back-to-back/reset: 3 queued 1-beat descriptors -> beats on cycles with exactly 1 idle gap; rst asserted mid-stream -> valid=0 next cycle, FIFOs empty, seq_err=0.

Source files
------------

// File: rtl/tgt_pyld_fetch_if.sv
// Handshake bundle for the payload fetch sequencer.
//   alloc channel : pbuf_alloc_{valid,last,buf_addr,qnum} in, pbuf_alloc_ready out
//   desc channel  : desc_{valid,blen,qnum,head} in, desc_ready out
//   free channel  : pbuf_free_{valid,last,head,buf_offset,buf_addr} out, pbuf_free_ready in
// The master modport is the sequencer's view; slave is the surrounding environment.
interface tgt_pyld_fetch_if #(
  parameter int unsigned BUF_ADDR_W = 10,
  parameter int unsigned BLEN_W     = 13,
  parameter int unsigned HEAD_W     = 64
);
  logic                  pbuf_alloc_valid;
  logic                  pbuf_alloc_last;
  logic [BUF_ADDR_W-1:0] pbuf_alloc_buf_addr;
  logic [7:0]            pbuf_alloc_qnum;
  logic                  pbuf_alloc_ready;

  logic                  desc_valid;
  logic [BLEN_W-1:0]     desc_blen;
  logic [7:0]            desc_qnum;
  logic [HEAD_W-1:0]     desc_head;
  logic                  desc_ready;

  logic                  pbuf_free_valid;
  logic                  pbuf_free_last;
  logic [HEAD_W-1:0]     pbuf_free_head;
  logic [1:0]            pbuf_free_buf_offset;
  logic [BUF_ADDR_W-1:0] pbuf_free_buf_addr;
  logic                  pbuf_free_ready;

  modport master (
    input  pbuf_alloc_valid, pbuf_alloc_last, pbuf_alloc_buf_addr, pbuf_alloc_qnum,
    output pbuf_alloc_ready,
    input  desc_valid, desc_blen, desc_qnum, desc_head,
    output desc_ready,
    output pbuf_free_valid, pbuf_free_last, pbuf_free_head, pbuf_free_buf_offset,
    output pbuf_free_buf_addr,
    input  pbuf_free_ready
  );

  modport slave (
    output pbuf_alloc_valid, pbuf_alloc_last, pbuf_alloc_buf_addr, pbuf_alloc_qnum,
    input  pbuf_alloc_ready,
    output desc_valid, desc_blen, desc_qnum, desc_head,
    input  desc_ready,
    input  pbuf_free_valid, pbuf_free_last, pbuf_free_head, pbuf_free_buf_offset,
    input  pbuf_free_buf_addr,
    output pbuf_free_ready
  );
endinterface

// File: rtl/tgt_pyld_fetch.sv
// Fetch sequencer for the P2P target payload buffer.
// Pairs buffer-allocation entries (one per filled 4-beat block or message tail) with message
// descriptors and emits one fetch/free request per data beat back to the payload buffer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : tgt_pyld_fetch_if.master (alloc sink, descriptor sink, free/fetch source)
//   seq_err  : sticky protocol-error flag, cleared only by rst
module tgt_pyld_fetch #(
  parameter int unsigned BUF_ADDR_W = 10,
  parameter int unsigned BLEN_W     = 13,
  parameter int unsigned HEAD_W     = 64,
  parameter int unsigned BEAT_BYTES = 32,
  parameter int unsigned AFIFO_LOG  = 4,
  parameter int unsigned DFIFO_LOG  = 3
) (
  input  logic             clk,
  input  logic             rst,
  tgt_pyld_fetch_if.master bus,
  output logic             seq_err
);

  localparam int unsigned AeW    = 1 + 8 + BUF_ADDR_W;
  localparam int unsigned DeW    = BLEN_W + 8 + HEAD_W;
  localparam int unsigned ADepth = 1 << AFIFO_LOG;
  localparam int unsigned DDepth = 1 << DFIFO_LOG;
  localparam int unsigned Shift  = $clog2(BEAT_BYTES);
  localparam int unsigned CntW   = BLEN_W - 4;

  typedef enum logic {StIdle, StFetch} state_e;

  // ---------------- allocation FIFO (show-ahead) ----------------
  logic [AeW-1:0]        amem [ADepth];
  logic [AFIFO_LOG:0]    awr_q, ard_q;
  logic                  afifo_empty, afifo_full, apush, apop;
  logic [AeW-1:0]        a_ent;
  logic                  a_last;
  logic [7:0]            a_qnum;
  logic [BUF_ADDR_W-1:0] a_addr;

  assign afifo_empty = (awr_q == ard_q);
  assign afifo_full  = (awr_q[AFIFO_LOG] != ard_q[AFIFO_LOG]) &&
                       (awr_q[AFIFO_LOG-1:0] == ard_q[AFIFO_LOG-1:0]);
  // Upstream ignores ready; a push into a full FIFO is dropped and flagged.
  assign apush  = bus.pbuf_alloc_valid && !afifo_full;
  assign a_ent  = amem[ard_q[AFIFO_LOG-1:0]];
  assign a_last = a_ent[AeW-1];
  assign a_qnum = a_ent[BUF_ADDR_W +: 8];
  assign a_addr = a_ent[BUF_ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      awr_q <= '0;
      ard_q <= '0;
    end else begin
      if (apush) awr_q <= awr_q + 1'b1;
      if (apop)  ard_q <= ard_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (apush) begin
      amem[awr_q[AFIFO_LOG-1:0]] <= {bus.pbuf_alloc_last, bus.pbuf_alloc_qnum,
                                     bus.pbuf_alloc_buf_addr};
    end
  end

  // ---------------- descriptor FIFO (show-ahead) ----------------
  logic [DeW-1:0]     dmem [DDepth];
  logic [DFIFO_LOG:0] dwr_q, drd_q;
  logic               dfifo_empty, dfifo_full, dpush, dpop;
  logic [DeW-1:0]     d_ent;
  logic [BLEN_W-1:0]  d_blen;
  logic [7:0]         d_qnum;
  logic [HEAD_W-1:0]  d_head;

  assign dfifo_empty = (dwr_q == drd_q);
  assign dfifo_full  = (dwr_q[DFIFO_LOG] != drd_q[DFIFO_LOG]) &&
                       (dwr_q[DFIFO_LOG-1:0] == drd_q[DFIFO_LOG-1:0]);
  assign dpush  = bus.desc_valid && !dfifo_full;
  assign d_ent  = dmem[drd_q[DFIFO_LOG-1:0]];
  assign d_blen = d_ent[DeW-1 -: BLEN_W];
  assign d_qnum = d_ent[HEAD_W +: 8];
  assign d_head = d_ent[HEAD_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      dwr_q <= '0;
      drd_q <= '0;
    end else begin
      if (dpush) dwr_q <= dwr_q + 1'b1;
      if (dpop)  drd_q <= drd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (dpush) dmem[dwr_q[DFIFO_LOG-1:0]] <= {bus.desc_blen, bus.desc_qnum, bus.desc_head};
  end

  // ---------------- beat count ----------------
  // One extra bit in the sum so blen near max cannot wrap before the shift.
  logic [BLEN_W:0] beat_sum, beat_shr;
  logic [CntW-1:0] beats;

  always_comb begin
    beat_sum = {1'b0, d_blen} + (BLEN_W+1)'(BEAT_BYTES - 1);
    beat_shr = beat_sum >> Shift;
    beats    = (beat_shr == '0) ? CntW'(1) : beat_shr[CntW-1:0];
  end

  // ---------------- sequencer FSM ----------------
  state_e            state_q, state_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [7:0]        qnum_q, qnum_d;
  logic [CntW-1:0]   left_q, left_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;

  logic                  free_valid, free_last;
  logic [1:0]            free_off;
  logic [BUF_ADDR_W-1:0] free_addr;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    qnum_d     = qnum_q;
    left_d     = left_q;
    idx_d      = idx_q;
    dpop       = 1'b0;
    apop       = 1'b0;
    free_valid = 1'b0;
    free_last  = 1'b0;
    free_off   = 2'd0;
    free_addr  = '0;

    unique case (state_q)
      StIdle: begin
        if (!dfifo_empty) begin
          dpop    = 1'b1;
          head_d  = d_head;
          qnum_d  = d_qnum;
          left_d  = beats;
          idx_d   = 2'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        free_valid = !afifo_empty;
        free_addr  = a_addr;
        free_off   = idx_q;
        free_last  = (left_q == CntW'(1));
        if (free_valid && bus.pbuf_free_ready) begin
          left_d = left_q - CntW'(1);
          idx_d  = idx_q + 2'd1;
          // A block is consumed after its 4th beat or at the message tail.
          apop   = (idx_q == 2'd3) || free_last;
          if (free_last) state_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (apop && ((a_last != free_last) || (a_qnum != qnum_q))) err_d = 1'b1;
    if (bus.pbuf_alloc_valid && afifo_full) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      head_q  <= '0;
      qnum_q  <= '0;
      left_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      qnum_q  <= qnum_d;
      left_q  <= left_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign bus.pbuf_alloc_ready     = !afifo_full;
  assign bus.desc_ready           = !dfifo_full;
  assign bus.pbuf_free_valid      = free_valid;
  assign bus.pbuf_free_last       = free_last;
  assign bus.pbuf_free_head       = head_q;
  assign bus.pbuf_free_buf_offset = free_off;
  assign bus.pbuf_free_buf_addr   = free_addr;
  assign seq_err                  = err_q;

endmodule

// File: tb/tb_tgt_pyld_fetch.sv
module tb_tgt_pyld_fetch;
  localparam int unsigned BUF_ADDR_W = 10;
  localparam int unsigned BLEN_W     = 13;
  localparam int unsigned HEAD_W     = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seq_err;

  always #5 clk = ~clk;

  tgt_pyld_fetch_if #(.BUF_ADDR_W(BUF_ADDR_W), .BLEN_W(BLEN_W), .HEAD_W(HEAD_W)) bus ();

  tgt_pyld_fetch #(
    .BUF_ADDR_W(BUF_ADDR_W), .BLEN_W(BLEN_W), .HEAD_W(HEAD_W),
    .BEAT_BYTES(32), .AFIFO_LOG(4), .DFIFO_LOG(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .seq_err(seq_err)
  );

  typedef struct {logic [9:0] addr; logic [1:0] off; logic last; logic [63:0] head;} beat_t;
  typedef struct {logic [9:0] addr; logic last; logic [7:0] qnum;} alloc_t;
  typedef struct {logic [12:0] blen; logic [7:0] qnum; logic [63:0] head;} desc_t;

  beat_t  exp_q[$];
  alloc_t alloc_q[$];
  desc_t  desc_q[$];

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  bit done = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pbuf_alloc_valid = 1'b0;
    bus.pbuf_alloc_last = 1'b0;
    bus.pbuf_alloc_buf_addr = '0;
    bus.pbuf_alloc_qnum = '0;
    bus.desc_valid = 1'b0;
    bus.desc_blen = '0;
    bus.desc_qnum = '0;
    bus.desc_head = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.pbuf_free_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drive_alloc(input logic [9:0] addr, input logic last, input logic [7:0] qnum);
    bus.pbuf_alloc_valid = 1'b1;
    bus.pbuf_alloc_buf_addr = addr;
    bus.pbuf_alloc_last = last;
    bus.pbuf_alloc_qnum = qnum;
  endtask

  task automatic drive_desc(input logic [12:0] blen, input logic [7:0] qnum,
                            input logic [63:0] head);
    bus.desc_valid = 1'b1;
    bus.desc_blen = blen;
    bus.desc_qnum = qnum;
    bus.desc_head = head;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    check_val({tag, ".v"}, 64'(bus.pbuf_free_valid), 64'd0);
    tick();
  endtask

  task automatic chk_beat(input string tag, input logic [9:0] addr, input logic [1:0] off,
                          input logic last, input logic [63:0] head);
    @(negedge clk);
    check_val({tag, ".v"}, 64'(bus.pbuf_free_valid), 64'd1);
    check_val({tag, ".addr"}, 64'(bus.pbuf_free_buf_addr), 64'(addr));
    check_val({tag, ".off"}, 64'(bus.pbuf_free_buf_offset), 64'(off));
    check_val({tag, ".last"}, 64'(bus.pbuf_free_last), 64'(last));
    check_val({tag, ".head"}, bus.pbuf_free_head, head);
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    check_val({tag, ".valid"}, 64'(bus.pbuf_free_valid), 64'd0);
    check_val({tag, ".last"}, 64'(bus.pbuf_free_last), 64'd0);
    check_val({tag, ".head"}, bus.pbuf_free_head, 64'd0);
    check_val({tag, ".off"}, 64'(bus.pbuf_free_buf_offset), 64'd0);
    check_val({tag, ".addr"}, 64'(bus.pbuf_free_buf_addr), 64'd0);
    check_val({tag, ".err"}, 64'(seq_err), 64'd0);
    check_val({tag, ".aready"}, 64'(bus.pbuf_alloc_ready), 64'd1);
    check_val({tag, ".dready"}, 64'(bus.desc_ready), 64'd1);
    tick();
  endtask

  // Scoreboard: every accepted beat must match the next expected beat; stalled beats hold.
  logic       prev_stall = 1'b0;
  logic [9:0] prev_addr;
  logic [1:0] prev_off;
  logic       prev_last;
  logic [63:0] prev_head;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check_val("stall.valid", 64'(bus.pbuf_free_valid), 64'd1);
        check_val("stall.addr", 64'(bus.pbuf_free_buf_addr), 64'(prev_addr));
        check_val("stall.off", 64'(bus.pbuf_free_buf_offset), 64'(prev_off));
        check_val("stall.last", 64'(bus.pbuf_free_last), 64'(prev_last));
        check_val("stall.head", bus.pbuf_free_head, prev_head);
      end
      if (bus.pbuf_free_valid && bus.pbuf_free_ready) begin
        if (exp_q.size() == 0) begin
          check_val("rand.extra_beat", 64'(bus.pbuf_free_valid), 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check_val("rand.addr", 64'(bus.pbuf_free_buf_addr), 64'(e.addr));
          check_val("rand.off", 64'(bus.pbuf_free_buf_offset), 64'(e.off));
          check_val("rand.last", 64'(bus.pbuf_free_last), 64'(e.last));
          check_val("rand.head", bus.pbuf_free_head, e.head);
        end
      end
      prev_stall = bus.pbuf_free_valid && !bus.pbuf_free_ready;
      prev_addr  = bus.pbuf_free_buf_addr;
      prev_off   = bus.pbuf_free_buf_offset;
      prev_last  = bus.pbuf_free_last;
      prev_head  = bus.pbuf_free_head;
    end
  end

  // Reference model: a message of blen bytes is max(1, ceil(blen/32)) beats, split into
  // 4-beat blocks, each block served from the next allocation entry in arrival order.
  task automatic add_msg(input logic [12:0] blen);
    int beats, blocks;
    logic [7:0] qnum;
    logic [63:0] head;
    beats  = (blen == 0) ? 1 : (int'(blen) + 31) / 32;
    blocks = (beats + 3) / 4;
    qnum   = 8'($urandom());
    head   = {$urandom(), $urandom()};
    for (int b = 0; b < blocks; b++) begin
      alloc_t a;
      a.addr = 10'($urandom());
      a.last = (b == blocks - 1);
      a.qnum = qnum;
      alloc_q.push_back(a);
      for (int o = 0; o < 4 && (4 * b + o) < beats; o++) begin
        beat_t e;
        e.addr = a.addr;
        e.off  = 2'(o);
        e.last = ((4 * b + o) == beats - 1);
        e.head = head;
        exp_q.push_back(e);
      end
    end
    desc_q.push_back('{blen: blen, qnum: qnum, head: head});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.pbuf_free_ready = 1'b1;
    do_reset();
    chk_reset_vals("reset");

    // Single message: 100 bytes -> 4 beats in one block.
    drive_desc(13'd100, 8'd7, 64'hA1A1_0000_0000_0001);
    drive_alloc(10'd5, 1'b1, 8'd7);
    chk_idle("t1.n0");
    idle_inputs();
    chk_idle("t1.n1");
    for (int i = 0; i < 4; i++) chk_beat("t1.beat", 10'd5, 2'(i), i == 3, 64'hA1A1_0000_0000_0001);
    chk_idle("t1.gap");
    @(negedge clk);
    check_val("t1.err", 64'(seq_err), 64'd0);
    tick();

    // Multi-block: 200 bytes -> 7 beats across two blocks.
    drive_desc(13'd200, 8'd3, 64'hB2B2_0000_0000_0002);
    drive_alloc(10'd9, 1'b0, 8'd3);
    chk_idle("t2.n0");
    bus.desc_valid = 1'b0;
    drive_alloc(10'd3, 1'b1, 8'd3);
    chk_idle("t2.n1");
    idle_inputs();
    for (int i = 0; i < 7; i++)
      chk_beat("t2.beat", (i < 4) ? 10'd9 : 10'd3, 2'(i % 4), i == 6, 64'hB2B2_0000_0000_0002);
    chk_idle("t2.gap");
    @(negedge clk);
    check_val("t2.err", 64'(seq_err), 64'd0);
    tick();

    // Backpressure: 64 bytes -> 2 beats, ready 1,0,0,1.
    drive_desc(13'd64, 8'd4, 64'hC3C3_0000_0000_0003);
    drive_alloc(10'd2, 1'b1, 8'd4);
    chk_idle("t3.n0");
    idle_inputs();
    chk_idle("t3.n1");
    chk_beat("t3.b0", 10'd2, 2'd0, 1'b0, 64'hC3C3_0000_0000_0003);
    bus.pbuf_free_ready = 1'b0;
    chk_beat("t3.hold0", 10'd2, 2'd1, 1'b1, 64'hC3C3_0000_0000_0003);
    chk_beat("t3.hold1", 10'd2, 2'd1, 1'b1, 64'hC3C3_0000_0000_0003);
    bus.pbuf_free_ready = 1'b1;
    chk_beat("t3.b1", 10'd2, 2'd1, 1'b1, 64'hC3C3_0000_0000_0003);
    chk_idle("t3.gap");

    // Allocation entry arrives 5 cycles after the descriptor.
    drive_desc(13'd96, 8'd5, 64'hD4D4_0000_0000_0004);
    chk_idle("t4.n0");
    idle_inputs();
    for (int i = 1; i < 5; i++) chk_idle("t4.wait");
    drive_alloc(10'd7, 1'b1, 8'd5);
    chk_idle("t4.n5");
    idle_inputs();
    for (int i = 0; i < 3; i++) chk_beat("t4.beat", 10'd7, 2'(i), i == 2, 64'hD4D4_0000_0000_0004);
    chk_idle("t4.gap");

    // Last-flag mismatch sets sticky seq_err.
    drive_desc(13'd32, 8'd6, 64'hE5E5_0000_0000_0005);
    drive_alloc(10'd8, 1'b0, 8'd6);
    chk_idle("t5.n0");
    idle_inputs();
    chk_idle("t5.n1");
    chk_beat("t5.beat", 10'd8, 2'd0, 1'b1, 64'hE5E5_0000_0000_0005);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t5.err_sticky", 64'(seq_err), 64'd1);
      tick();
    end
    do_reset();
    @(negedge clk);
    check_val("t5.err_cleared", 64'(seq_err), 64'd0);
    tick();

    // Queue-number mismatch.
    drive_desc(13'd32, 8'd1, 64'hE6E6_0000_0000_0006);
    drive_alloc(10'd4, 1'b1, 8'd2);
    chk_idle("t5b.n0");
    idle_inputs();
    chk_idle("t5b.n1");
    chk_beat("t5b.beat", 10'd4, 2'd0, 1'b1, 64'hE6E6_0000_0000_0006);
    @(negedge clk);
    check_val("t5b.err", 64'(seq_err), 64'd1);
    tick();
    do_reset();

    // Back-to-back 1-beat messages with exactly one idle cycle between them.
    for (int i = 0; i < 3; i++) begin
      drive_desc(13'd32, 8'(i), 64'(i + 16));
      drive_alloc(10'(10 + i), 1'b1, 8'(i));
      if (i < 2) chk_idle("t6.fill");
    end
    chk_beat("t6.m0", 10'd10, 2'd0, 1'b1, 64'd16);
    idle_inputs();
    chk_idle("t6.gap0");
    chk_beat("t6.m1", 10'd11, 2'd0, 1'b1, 64'd17);
    chk_idle("t6.gap1");
    chk_beat("t6.m2", 10'd12, 2'd0, 1'b1, 64'd18);
    chk_idle("t6.gap2");

    // Reset in the middle of a 10-beat message.
    drive_desc(13'd320, 8'd9, 64'hF7F7_0000_0000_0007);
    drive_alloc(10'd20, 1'b0, 8'd9);
    chk_idle("t7.n0");
    bus.desc_valid = 1'b0;
    drive_alloc(10'd21, 1'b0, 8'd9);
    chk_idle("t7.n1");
    idle_inputs();
    chk_beat("t7.b0", 10'd20, 2'd0, 1'b0, 64'hF7F7_0000_0000_0007);
    chk_beat("t7.b1", 10'd20, 2'd1, 1'b0, 64'hF7F7_0000_0000_0007);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("t7.rst");
    for (int i = 0; i < 3; i++) chk_idle("t7.quiet");
    // Flushed allocation FIFO: the next message must use the fresh entry.
    drive_desc(13'd32, 8'd2, 64'h1234);
    drive_alloc(10'd30, 1'b1, 8'd2);
    chk_idle("t7.n2");
    idle_inputs();
    chk_idle("t7.n3");
    chk_beat("t7.fresh", 10'd30, 2'd0, 1'b1, 64'h1234);
    @(negedge clk);
    check_val("t7.err", 64'(seq_err), 64'd0);
    tick();

    // Allocation FIFO full: ready drops after 16 entries, an extra push is flagged.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_alloc(10'(i), 1'b0, 8'd1);
      @(negedge clk);
      check_val("t8.ready_fill", 64'(bus.pbuf_alloc_ready), 64'd1);
      tick();
    end
    drive_alloc(10'd99, 1'b0, 8'd1);
    @(negedge clk);
    check_val("t8.ready_full", 64'(bus.pbuf_alloc_ready), 64'd0);
    check_val("t8.err_before", 64'(seq_err), 64'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check_val("t8.err_overflow", 64'(seq_err), 64'd1);
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    exp_q.delete();
    alloc_q.delete();
    desc_q.delete();
    add_msg(13'd8191);
    add_msg(13'd0);
    for (int m = 0; m < 60; m++) begin
      case ($urandom_range(0, 5))
        0:       add_msg(13'd0);
        1:       add_msg(13'(32 * $urandom_range(1, 8)));
        2:       add_msg(13'(32 * $urandom_range(0, 8) + 1));
        default: add_msg(13'($urandom_range(1, 700)));
      endcase
    end
    mon_en = 1'b1;
    done = 1'b0;
    fork
      begin
        while (alloc_q.size() > 0 && !done) begin
          alloc_t a;
          repeat ($urandom_range(0, 2)) tick();
          while (!bus.pbuf_alloc_ready && !done) tick();
          a = alloc_q.pop_front();
          drive_alloc(a.addr, a.last, a.qnum);
          tick();
          bus.pbuf_alloc_valid = 1'b0;
        end
      end
      begin
        while (desc_q.size() > 0 && !done) begin
          desc_t d;
          repeat ($urandom_range(0, 6)) tick();
          while (!bus.desc_ready && !done) tick();
          d = desc_q.pop_front();
          drive_desc(d.blen, d.qnum, d.head);
          tick();
          bus.desc_valid = 1'b0;
        end
      end
      begin
        while (!done) begin
          bus.pbuf_free_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        bus.pbuf_free_ready = 1'b1;
      end
      begin
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < 20000) begin
          tick();
          cyc++;
        end
        check_val("rand.timeout_left", 64'(exp_q.size()), 64'd0);
        repeat (4) tick();
        done = 1'b1;
      end
    join
    mon_en = 1'b0;
    @(negedge clk);
    check_val("rand.err", 64'(seq_err), 64'd0);
    check_val("rand.idle", 64'(bus.pbuf_free_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
